// File: rtl/race_pkg.sv
// Shared definitions for the PUF race launcher: state encoding, default
// parameters and the challenge rotation helper.
package race_pkg;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ARM     = 3'd1;
    localparam logic [2:0] LAUNCH  = 3'd2;
    localparam logic [2:0] WAIT    = 3'd3;
    localparam logic [2:0] RECOVER = 3'd4;

    localparam int DEF_CHAL_WIDTH = 8;
    localparam int DEF_RESP_BITS  = 8;
    localparam int DEF_SETTLE     = 4;
    localparam int DEF_TIMEOUT    = 255;

    // Rotate the low w bits of v left by n positions (w <= 32).
    function automatic logic [31:0] rotl(input logic [31:0] v, input int w, input int n);
        logic [31:0] r;
        int          s;
        r = '0;
        s = n % w;
        for (int i = 0; i < 32; i++) begin
            if (i < w) r[5'((i + s) % w)] = v[5'(i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/race_launcher_sync.sv
// Two-flop synchronizer for the asynchronous arbiter outputs.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d_in,
    output logic q_out
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
        end
    end

    assign q_out = sync_q;

endmodule

// File: rtl/race_launcher.sv
// Launch-side sequencer for the serial PUF race: settles each rotated
// challenge, fires the race, captures the winner and assembles a response.
module race_launcher
    import race_pkg::*;
#(
    parameter int CHAL_WIDTH = DEF_CHAL_WIDTH,
    parameter int RESP_BITS  = DEF_RESP_BITS,
    parameter int SETTLE     = DEF_SETTLE,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chal_valid,
    output logic                  chal_ready,
    input  logic [CHAL_WIDTH-1:0] challenge,
    output logic [CHAL_WIDTH-1:0] race_challenge,
    output logic                  race_start,
    output logic                  arb_reset,
    input  logic                  arb_done,
    input  logic                  arb_out,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [RESP_BITS-1:0]  resp_data,
    output logic                  resp_timeout
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(SETTLE + 1);
    localparam int BW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [WW-1:0] WAIT_LIMIT  = WW'(TIMEOUT);
    localparam logic [BW-1:0] LAST_BIT    = BW'(RESP_BITS - 1);

    logic                  done_s;
    logic                  out_s;

    logic [2:0]            state_q,        state_d;
    logic [CHAL_WIDTH-1:0] chal_q,         chal_d;
    logic [CHAL_WIDTH-1:0] race_chal_q,    race_chal_d;
    logic [BW-1:0]         bit_idx_q,      bit_idx_d;
    logic [SW-1:0]         settle_cnt_q,   settle_cnt_d;
    logic [WW-1:0]         wait_cnt_q,     wait_cnt_d;
    logic [RESP_BITS-1:0]  resp_data_q,    resp_data_d;
    logic                  resp_timeout_q, resp_timeout_d;
    logic                  resp_valid_q,   resp_valid_d;
    logic [31:0]           rot_next;

    sync2 u_sync_done (
        .clk   (clk),
        .reset (reset),
        .d_in  (arb_done),
        .q_out (done_s)
    );

    sync2 u_sync_out (
        .clk   (clk),
        .reset (reset),
        .d_in  (arb_out),
        .q_out (out_s)
    );

    // The arbiter is only released while a race is actually in flight.
    assign race_start     = (state_q == LAUNCH) || (state_q == WAIT);
    assign arb_reset      = ~race_start;
    assign chal_ready     = (state_q == IDLE) && !resp_valid_q;
    assign race_challenge = race_chal_q;
    assign resp_valid     = resp_valid_q;
    assign resp_data      = resp_data_q;
    assign resp_timeout   = resp_timeout_q;

    always_comb begin
        state_d        = state_q;
        chal_d         = chal_q;
        race_chal_d    = race_chal_q;
        bit_idx_d      = bit_idx_q;
        settle_cnt_d   = settle_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        resp_data_d    = resp_data_q;
        resp_timeout_d = resp_timeout_q;
        resp_valid_d   = resp_valid_q;
        rot_next       = rotl(32'(chal_q), CHAL_WIDTH, int'(bit_idx_q) + 1);

        if (resp_valid_q && resp_ready) resp_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (chal_valid && chal_ready) begin
                    chal_d         = challenge;
                    race_chal_d    = challenge;
                    bit_idx_d      = '0;
                    settle_cnt_d   = '0;
                    resp_data_d    = '0;
                    resp_timeout_d = 1'b0;
                    state_d        = ARM;
                end
            end
            ARM: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = LAUNCH;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            LAUNCH: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                // A real result wins over a timeout landing in the same cycle.
                if (done_s) begin
                    resp_data_d[bit_idx_q] = out_s;
                    state_d                = RECOVER;
                end else if (wait_cnt_d == WAIT_LIMIT) begin
                    resp_data_d[bit_idx_q] = 1'b0;
                    resp_timeout_d         = 1'b1;
                    state_d                = RECOVER;
                end
            end
            RECOVER: begin
                if (!done_s) begin
                    if (bit_idx_q == LAST_BIT) begin
                        resp_valid_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        bit_idx_d    = bit_idx_q + 1'b1;
                        race_chal_d  = rot_next[CHAL_WIDTH-1:0];
                        settle_cnt_d = '0;
                        state_d      = ARM;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            chal_q         <= '0;
            race_chal_q    <= '0;
            bit_idx_q      <= '0;
            settle_cnt_q   <= '0;
            wait_cnt_q     <= '0;
            resp_data_q    <= '0;
            resp_timeout_q <= 1'b0;
            resp_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            chal_q         <= chal_d;
            race_chal_q    <= race_chal_d;
            bit_idx_q      <= bit_idx_d;
            settle_cnt_q   <= settle_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            resp_data_q    <= resp_data_d;
            resp_timeout_q <= resp_timeout_d;
            resp_valid_q   <= resp_valid_d;
        end
    end

endmodule
